// File: rtl/mem_write_checker.sv
// Self-check monitor for the MIPS data-memory write port: compares observed stores
// against a loadable table of expected (addr,data) pairs and reports pass/fail/timeout.
module mem_write_checker #(
    parameter int NUM_CHECKS  = 4,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 1000,
    parameter int ORDERED     = 1,
    localparam int IW = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1,
    localparam int CW = $clog2(NUM_CHECKS + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              memwrite,
    input  logic [ADDR_W-1:0] dataadr,
    input  logic [DATA_W-1:0] writedata,
    input  logic              exp_we,
    input  logic [IW-1:0]     exp_idx,
    input  logic [ADDR_W-1:0] exp_addr,
    input  logic [DATA_W-1:0] exp_data,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              fail,
    output logic              timeout,
    output logic [CW-1:0]     match_count,
    output logic [15:0]       other_count,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_data
);

    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PASS, S_FAIL} state_t;

    state_t                state, next_state;
    logic [ADDR_W-1:0]     tab_addr [NUM_CHECKS];
    logic [DATA_W-1:0]     tab_data [NUM_CHECKS];
    logic [NUM_CHECKS-1:0] matched;
    logic [NUM_CHECKS-1:0] hit_mask;
    logic [CW-1:0]         ptr;
    logic [TW-1:0]         cyc;
    logic [ADDR_W-1:0]     cur_addr;
    logic [DATA_W-1:0]     cur_data;
    logic                  hit, bad, other, final_hit, to_flag, addr_seen, data_hit;

    // Classify the current store, then decide the next state; a final match beats a timeout.
    always_comb begin
        next_state = state;
        hit        = 1'b0;
        bad        = 1'b0;
        other      = 1'b0;
        hit_mask   = '0;
        cur_addr   = '0;
        cur_data   = '0;
        addr_seen  = 1'b0;
        data_hit   = 1'b0;
        for (int i = 0; i < NUM_CHECKS; i++) begin
            if (ptr == CW'(i)) begin
                cur_addr = tab_addr[i];
                cur_data = tab_data[i];
            end
        end
        if (ORDERED != 0) begin
            for (int i = 0; i < NUM_CHECKS; i++)
                hit_mask[i] = (ptr == CW'(i));
            if (memwrite) begin
                if (dataadr == cur_addr) begin
                    hit = (writedata == cur_data);
                    bad = (writedata != cur_data);
                end else begin
                    other = 1'b1;
                end
            end
        end else begin
            // Descending scan so the lowest matching index is the one left selected.
            for (int i = NUM_CHECKS - 1; i >= 0; i--) begin
                if (!matched[i] && dataadr == tab_addr[i]) begin
                    addr_seen = 1'b1;
                    if (writedata == tab_data[i]) begin
                        data_hit    = 1'b1;
                        hit_mask    = '0;
                        hit_mask[i] = 1'b1;
                    end
                end
            end
            if (memwrite) begin
                hit   = data_hit;
                bad   = !data_hit && addr_seen;
                other = !data_hit && !addr_seen;
            end
        end
        final_hit = hit && (match_count == CW'(NUM_CHECKS - 1));
        to_flag   = (state == S_RUN) && !final_hit && !bad && (cyc == TW'(TIMEOUT_CYC - 1));
        case (state)
            S_RUN: begin
                if (final_hit)            next_state = S_PASS;
                else if (bad || to_flag)  next_state = S_FAIL;
            end
            default: begin
                if (start) next_state = S_RUN;
            end
        endcase
    end

    // State, table and diagnostic registers; the table is writable only outside RUN.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            matched     <= '0;
            ptr         <= '0;
            cyc         <= '0;
            timeout     <= 1'b0;
            match_count <= '0;
            other_count <= '0;
            fail_addr   <= '0;
            fail_data   <= '0;
            for (int i = 0; i < NUM_CHECKS; i++) begin
                tab_addr[i] <= '0;
                tab_data[i] <= '0;
            end
        end else begin
            state <= next_state;
            if (state != S_RUN && exp_we) begin
                for (int i = 0; i < NUM_CHECKS; i++) begin
                    if (exp_idx == IW'(i)) begin
                        tab_addr[i] <= exp_addr;
                        tab_data[i] <= exp_data;
                    end
                end
            end
            if (state != S_RUN && start) begin
                matched     <= '0;
                ptr         <= '0;
                cyc         <= '0;
                timeout     <= 1'b0;
                match_count <= '0;
                other_count <= '0;
                fail_addr   <= '0;
                fail_data   <= '0;
            end else if (state == S_RUN) begin
                cyc <= cyc + 1'b1;
                if (hit) begin
                    matched     <= matched | hit_mask;
                    ptr         <= ptr + 1'b1;
                    match_count <= match_count + 1'b1;
                end
                if (other && other_count != 16'hFFFF)
                    other_count <= other_count + 1'b1;
                if (bad) begin
                    fail_addr <= dataadr;
                    fail_data <= writedata;
                end
                if (to_flag)
                    timeout <= 1'b1;
            end
        end
    end

    assign busy = (state == S_RUN);
    assign pass = (state == S_PASS);
    assign fail = (state == S_FAIL);
    assign done = pass || fail;

endmodule

// File: tb/tb_mem_write_checker.sv
// Directed bench: ordered, unordered and single-entry checkers share one stimulus stream
// and are compared against hand-computed expectations.
module tb_mem_write_checker;

    logic        clk = 1'b0;
    logic        reset, memwrite, exp_we, start;
    logic [31:0] dataadr, writedata, exp_addr, exp_data;
    logic [0:0]  exp_idx;

    logic        o_busy, o_done, o_pass, o_fail, o_timeout;
    logic [1:0]  o_mc;
    logic [15:0] o_other;
    logic [31:0] o_faddr, o_fdata;
    logic        u_busy, u_done, u_pass, u_fail, u_timeout;
    logic [1:0]  u_mc;
    logic [15:0] u_other;
    logic [31:0] u_faddr, u_fdata;
    logic        s_busy, s_done, s_pass, s_fail, s_timeout;
    logic [0:0]  s_mc;
    logic [15:0] s_other;
    logic [31:0] s_faddr, s_fdata;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_write_checker #(.NUM_CHECKS(2), .TIMEOUT_CYC(10), .ORDERED(1)) dut_o (
        .clk(clk), .reset(reset), .memwrite(memwrite), .dataadr(dataadr), .writedata(writedata),
        .exp_we(exp_we), .exp_idx(exp_idx), .exp_addr(exp_addr), .exp_data(exp_data), .start(start),
        .busy(o_busy), .done(o_done), .pass(o_pass), .fail(o_fail), .timeout(o_timeout),
        .match_count(o_mc), .other_count(o_other), .fail_addr(o_faddr), .fail_data(o_fdata));

    mem_write_checker #(.NUM_CHECKS(2), .TIMEOUT_CYC(10), .ORDERED(0)) dut_u (
        .clk(clk), .reset(reset), .memwrite(memwrite), .dataadr(dataadr), .writedata(writedata),
        .exp_we(exp_we), .exp_idx(exp_idx), .exp_addr(exp_addr), .exp_data(exp_data), .start(start),
        .busy(u_busy), .done(u_done), .pass(u_pass), .fail(u_fail), .timeout(u_timeout),
        .match_count(u_mc), .other_count(u_other), .fail_addr(u_faddr), .fail_data(u_fdata));

    mem_write_checker #(.NUM_CHECKS(1), .TIMEOUT_CYC(10), .ORDERED(1)) dut_s (
        .clk(clk), .reset(reset), .memwrite(memwrite), .dataadr(dataadr), .writedata(writedata),
        .exp_we(exp_we), .exp_idx(exp_idx), .exp_addr(exp_addr), .exp_data(exp_data), .start(start),
        .busy(s_busy), .done(s_done), .pass(s_pass), .fail(s_fail), .timeout(s_timeout),
        .match_count(s_mc), .other_count(s_other), .fail_addr(s_faddr), .fail_data(s_fdata));

    typedef struct {
        logic        mw;
        logic [31:0] a;
        logic [31:0] d;
        logic        o_pass;
        int          o_mc;
        int          o_oth;
        logic        u_pass;
        int          u_mc;
        int          u_oth;
        logic        s_pass;
        int          s_mc;
        int          s_oth;
    } vec_t;

    vec_t vecs [4];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one store (or idle cycle) and advance past the sampling edge.
    task automatic applyStimulus(input logic mw, input logic [31:0] a, input logic [31:0] d);
        memwrite  = mw;
        dataadr   = a;
        writedata = d;
        tick();
        memwrite  = 1'b0;
    endtask

    task automatic loadEntry(input logic [0:0] idx, input logic [31:0] a, input logic [31:0] d);
        exp_we   = 1'b1;
        exp_idx  = idx;
        exp_addr = a;
        exp_data = d;
        tick();
        exp_we   = 1'b0;
    endtask

    task automatic startRun();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        reset = 1'b1; memwrite = 1'b0; exp_we = 1'b0; start = 1'b0;
        dataadr = '0; writedata = '0; exp_idx = '0; exp_addr = '0; exp_data = '0;

        vecs[0] = '{1'b0, 32'd0, 32'd0, 1'b0, 0, 0, 1'b0, 0, 0, 1'b0, 0, 0};
        vecs[1] = '{1'b1, 32'd4, 32'd6, 1'b0, 0, 1, 1'b0, 1, 0, 1'b0, 0, 1};
        vecs[2] = '{1'b1, 32'd0, 32'd5, 1'b0, 1, 1, 1'b1, 2, 0, 1'b1, 1, 1};
        vecs[3] = '{1'b1, 32'd4, 32'd6, 1'b1, 2, 1, 1'b1, 2, 0, 1'b1, 1, 1};

        tick(); tick();
        reset = 1'b0;
        checkOutput("reset o_busy", o_busy, 0);
        checkOutput("reset o_done", o_done, 0);
        checkOutput("reset u_mc", u_mc, 0);
        checkOutput("reset s_other", s_other, 0);
        checkOutput("reset s_faddr", s_faddr, 0);

        // Table (0,5),(4,6); the single-entry checker ignores idx 1.
        loadEntry(0, 32'd0, 32'd5);
        loadEntry(1, 32'd4, 32'd6);
        startRun();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(vecs[i].mw, vecs[i].a, vecs[i].d);
            checkOutput($sformatf("vec%0d o_pass", i), o_pass, vecs[i].o_pass);
            checkOutput($sformatf("vec%0d o_mc", i), o_mc, vecs[i].o_mc);
            checkOutput($sformatf("vec%0d o_other", i), o_other, vecs[i].o_oth);
            checkOutput($sformatf("vec%0d u_pass", i), u_pass, vecs[i].u_pass);
            checkOutput($sformatf("vec%0d u_mc", i), u_mc, vecs[i].u_mc);
            checkOutput($sformatf("vec%0d u_other", i), u_other, vecs[i].u_oth);
            checkOutput($sformatf("vec%0d s_pass", i), s_pass, vecs[i].s_pass);
            checkOutput($sformatf("vec%0d s_mc", i), s_mc, vecs[i].s_mc);
            checkOutput($sformatf("vec%0d s_other", i), s_other, vecs[i].s_oth);
            checkOutput($sformatf("vec%0d o_fail", i), o_fail, 0);
        end

        // Classic (84,7) check, then a data mismatch on entry 1.
        loadEntry(0, 32'd84, 32'd7);
        loadEntry(1, 32'd88, 32'd1);
        startRun();
        checkOutput("B start o_busy", o_busy, 1);
        checkOutput("B start o_mc", o_mc, 0);
        applyStimulus(1'b1, 32'd80, 32'd3);
        checkOutput("B1 s_other", s_other, 1);
        checkOutput("B1 s_pass", s_pass, 0);
        applyStimulus(1'b1, 32'd84, 32'd7);
        checkOutput("B2 s_pass", s_pass, 1);
        checkOutput("B2 s_fail", s_fail, 0);
        checkOutput("B2 o_mc", o_mc, 1);
        checkOutput("B2 o_pass", o_pass, 0);
        applyStimulus(1'b1, 32'd84, 32'd9);
        checkOutput("B3 o_other", o_other, 2);
        checkOutput("B3 u_other", u_other, 2);
        checkOutput("B3 u_fail", u_fail, 0);
        applyStimulus(1'b1, 32'd88, 32'd2);
        checkOutput("B4 o_fail", o_fail, 1);
        checkOutput("B4 o_faddr", o_faddr, 88);
        checkOutput("B4 o_fdata", o_fdata, 2);
        checkOutput("B4 o_mc", o_mc, 1);
        checkOutput("B4 u_fail", u_fail, 1);
        checkOutput("B4 u_timeout", u_timeout, 0);
        checkOutput("B4 s_pass", s_pass, 1);

        // Wrong data at the expected address.
        startRun();
        applyStimulus(1'b1, 32'd84, 32'd9);
        checkOutput("C s_fail", s_fail, 1);
        checkOutput("C s_done", s_done, 1);
        checkOutput("C s_timeout", s_timeout, 0);
        checkOutput("C s_faddr", s_faddr, 84);
        checkOutput("C s_fdata", s_fdata, 9);
        checkOutput("C s_mc", s_mc, 0);
        checkOutput("C o_faddr", o_faddr, 84);

        // Timeout exactly ten cycles after entering RUN.
        startRun();
        for (int k = 1; k <= 9; k++) applyStimulus(1'b0, 32'd0, 32'd0);
        checkOutput("D9 s_busy", s_busy, 1);
        checkOutput("D9 s_fail", s_fail, 0);
        applyStimulus(1'b0, 32'd0, 32'd0);
        checkOutput("D10 s_fail", s_fail, 1);
        checkOutput("D10 s_timeout", s_timeout, 1);
        checkOutput("D10 s_faddr", s_faddr, 0);
        checkOutput("D10 o_timeout", o_timeout, 1);

        // Final match on the timeout cycle: pass wins for the single entry checker.
        startRun();
        for (int k = 1; k <= 9; k++) applyStimulus(1'b0, 32'd0, 32'd0);
        applyStimulus(1'b1, 32'd84, 32'd7);
        checkOutput("D2 s_pass", s_pass, 1);
        checkOutput("D2 s_timeout", s_timeout, 0);
        checkOutput("D2 o_fail", o_fail, 1);
        checkOutput("D2 o_timeout", o_timeout, 1);
        checkOutput("D2 o_mc", o_mc, 1);

        // Reset in the middle of a run after one match.
        loadEntry(0, 32'd0, 32'd5);
        loadEntry(1, 32'd4, 32'd6);
        startRun();
        applyStimulus(1'b1, 32'd0, 32'd5);
        checkOutput("E o_mc", o_mc, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkOutput("E rst o_busy", o_busy, 0);
        checkOutput("E rst o_mc", o_mc, 0);
        checkOutput("E rst o_done", o_done, 0);
        checkOutput("E rst s_pass", s_pass, 0);
        checkOutput("E rst u_busy", u_busy, 0);

        // Table writes while running must be ignored.
        loadEntry(0, 32'd0, 32'd5);
        loadEntry(1, 32'd4, 32'd6);
        startRun();
        loadEntry(1, 32'd8, 32'd8);
        applyStimulus(1'b1, 32'd0, 32'd5);
        applyStimulus(1'b1, 32'd4, 32'd6);
        checkOutput("F o_pass", o_pass, 1);
        checkOutput("F o_mc", o_mc, 2);
        checkOutput("F u_pass", u_pass, 1);

        // Table write and start together: the new entry is used.
        exp_we = 1'b1; exp_idx = 1'b1; exp_addr = 32'd12; exp_data = 32'd3;
        start = 1'b1;
        tick();
        exp_we = 1'b0; start = 1'b0;
        applyStimulus(1'b1, 32'd0, 32'd5);
        applyStimulus(1'b1, 32'd12, 32'd3);
        checkOutput("G o_pass", o_pass, 1);
        checkOutput("G o_other", o_other, 0);
        checkOutput("G u_pass", u_pass, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
